// File: rtl/cpu_pkg.sv
// ============================================================
// cpu_pkg: shared data-memory widths and store-buffer entry type
// Rev 1.0
// ============================================================
`default_nettype none

package cpu_pkg;
    localparam int DATA_W  = 16;
    localparam int DADDR_W = 5;

    typedef struct packed {
        logic [DADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } sb_entry_t;
endpackage

`default_nettype wire

// File: rtl/sb_fifo.sv
// ============================================================
// sb_fifo: store-buffer entry FIFO with parallel entry read-out
// Rev 1.0
// ============================================================
`default_nettype none

module sb_fifo import cpu_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  sb_entry_t                push_entry,
    input  logic                     pop,
    output sb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [DEPTH-1:0] r_valid;
    sb_entry_t        r_mem [DEPTH];

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (pop)  r_valid[r_rd_ptr] <= 1'b0;
            if (push) r_valid[r_wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_entry;
    end

    assign entries = r_mem;
    assign valid   = r_valid;
    assign rd_ptr  = r_rd_ptr;
    assign count   = r_count;
endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================
// store_buffer: posted-write buffer with load priority and forwarding
// Rev 1.0
// ============================================================
`default_nettype none

module store_buffer import cpu_pkg::*; #(
    parameter int DEPTH        = 4,
    parameter int AW           = DADDR_W,
    parameter int DW           = DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    output logic [DW-1:0]          ld_data,
    output logic                   ld_stall,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_din,
    input  logic [DW-1:0]          mem_dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);

    sb_entry_t        w_entries [DEPTH];
    sb_entry_t        w_head;
    sb_entry_t        w_push_entry;
    logic [DEPTH-1:0] w_valid;
    logic [PW-1:0]    w_rd_ptr;
    logic [CW-1:0]    w_count;
    logic [PW-1:0]    w_idx;
    logic             w_empty;
    logic             w_push;
    logic             w_force;
    logic             w_load;
    logic             w_drain;
    logic [SW-1:0]    r_starve;

    assign w_push_entry = '{addr: st_addr, data: st_data};
    assign w_empty      = (w_count == '0);
    assign st_ready     = (w_count != CW'(DEPTH));
    assign w_push       = st_valid && st_ready;
    assign w_head       = w_entries[w_rd_ptr];

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_drain),
        .entries    (w_entries),
        .valid      (w_valid),
        .rd_ptr     (w_rd_ptr),
        .count      (w_count)
    );

    // Loads own the port unless the queue has waited too long behind them.
    assign w_force  = (r_starve == c_starve_max) && !w_empty;
    assign w_load   = ld_valid && !w_force;
    assign w_drain  = (!ld_valid || w_force) && !w_empty;

    assign ld_stall = ld_valid && w_force;
    assign mem_we   = w_drain;
    assign mem_addr = w_load ? ld_addr : (w_drain ? w_head.addr : '0);
    assign mem_din  = w_drain ? w_head.data : '0;
    assign empty    = w_empty;
    assign count    = w_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_drain || w_empty) begin
            r_starve <= '0;
        end else if (w_load && (r_starve != c_starve_max)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        ld_data = mem_dout;
        w_idx   = w_rd_ptr;
        if (w_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = w_rd_ptr + PW'(i);
                if (w_valid[w_idx] && (w_entries[w_idx].addr == ld_addr))
                    ld_data = w_entries[w_idx].data;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================
// tb_store_buffer: directed scoreboard bench for store_buffer
// Rev 1.0
// ============================================================
`default_nettype none

module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          st_valid = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          empty;
    logic [$clog2(DEPTH):0] count;

    logic [DW-1:0] mem [32];
    logic          mem_init = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] sbq [$];

    logic          s_mem_we;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_din;
    logic          s_ld_stall;
    logic [DW-1:0] s_ld_data;

    logic [AW-1:0] t5_addr [6] = '{5'd16, 5'd17, 5'd25, 5'd25, 5'd18, 5'd19};

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic lv, input logic [AW-1:0] la);
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
    endtask

    // One clock cycle: sample at negedge, score drains/loads, record accepted store.
    task automatic cycle();
        logic             full;
        logic [DW-1:0]    exp_ld;
        logic [AW+DW-1:0] e;
        @(negedge clk);
        s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_din = mem_din;
        s_ld_stall = ld_stall; s_ld_data = ld_data;
        full = (sbq.size() == DEPTH);
        chk("st_ready", st_ready, !full);
        chk("count", count, sbq.size());
        chk("empty", empty, sbq.size() == 0);
        if (ld_valid && !ld_stall) begin
            exp_ld = mem[ld_addr];
            foreach (sbq[i]) if (sbq[i][AW+DW-1:DW] == ld_addr) exp_ld = sbq[i][DW-1:0];
            chk("ld_data", ld_data, exp_ld);
            chk("load_no_we", mem_we, 0);
        end
        if (sbq.size() == 0) begin
            chk("idle_we", mem_we, 0);
        end else if (mem_we) begin
            e = sbq.pop_front();
            chk("drain_addr", mem_addr, e[AW+DW-1:DW]);
            chk("drain_data", mem_din, e[DW-1:0]);
        end
        if (st_valid && !full) sbq.push_back({st_addr, st_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_ld_stall", ld_stall, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        mem_init = 1'b0;
        rst_n    = 1'b1;

        // Single store drains on the following cycle
        drive(1, 5'd3, 16'hBEEF, 0, 5'd0); cycle();
        drive(0, 5'd0, 16'h0, 0, 5'd0);    cycle();
        chk("t1_we", s_mem_we, 1);
        chk("t1_addr", s_mem_addr, 3);
        chk("t1_din", s_mem_din, 16'hBEEF);
        cycle();
        chk("t1_mem", mem[3], 16'hBEEF);

        // Youngest-match forwarding while a load holds the port
        drive(1, 5'd5, 16'h1111, 1, 5'd5); cycle();
        drive(1, 5'd5, 16'h2222, 1, 5'd5); cycle();
        drive(0, 5'd0, 16'h0, 1, 5'd5);    cycle();
        chk("t2_fwd", s_ld_data, 16'h2222);
        chk("t2_we", s_mem_we, 0);
        drive(0, 5'd0, 16'h0, 0, 5'd0);
        repeat (3) cycle();
        chk("t2_mem_last", mem[5], 16'h2222);

        // Fill to full behind loads, then a rejected fifth store
        for (int k = 0; k < 4; k++) begin
            drive(1, 5'(10 + k), 16'hA000 + 16'(k), 1, 5'd20);
            cycle();
        end
        drive(1, 5'd14, 16'hA004, 1, 5'd20); cycle();
        drive(0, 5'd0, 16'h0, 1, 5'd20);
        @(negedge clk);
        chk("t3_count", count, 4);
        chk("t3_ready", st_ready, 0);
        @(posedge clk); #1;

        // Drop loads and keep presenting stores: drain overlaps push
        for (int k = 0; k < 6; k++) begin
            drive(1, t5_addr[k], 16'hB000 + 16'(k), 0, 5'd0);
            cycle();
        end
        drive(0, 5'd0, 16'h0, 0, 5'd0);
        for (int k = 0; k < 10 && sbq.size() != 0; k++) cycle();
        @(negedge clk);
        chk("t5_empty", empty, 1);
        chk("t5_last_wins", mem[25], 16'hB003);
        @(posedge clk); #1;

        // Starvation: eight load cycles, then a forced drain with stall
        drive(1, 5'd7, 16'h7777, 1, 5'd9); cycle();
        drive(0, 5'd0, 16'h0, 1, 5'd9);
        for (int c = 1; c <= 8; c++) begin
            cycle();
            chk("t4_no_stall", s_ld_stall, 0);
            chk("t4_no_we", s_mem_we, 0);
        end
        cycle();
        chk("t4_stall", s_ld_stall, 1);
        chk("t4_force_we", s_mem_we, 1);
        chk("t4_force_addr", s_mem_addr, 7);
        cycle();
        chk("t4_served", s_ld_stall, 0);
        chk("t4_served_data", s_ld_data, 16'h1009);

        // Reset in the middle of draining three queued stores
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(28 + k), 16'hD000 + 16'(k), 1, 5'd0);
            cycle();
        end
        drive(0, 5'd0, 16'h0, 0, 5'd0); cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_we", mem_we, 0);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_mem28", mem[28], 16'hD000);
        chk("t6_mem29", mem[29], 16'h101D);
        chk("t6_mem30", mem[30], 16'h101E);
        rst_n = 1'b1;
        repeat (2) cycle();
        chk("t6_mem29_after", mem[29], 16'h101D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
